// File: rtl/bridge_pkg.sv
// Shared definitions for the UART bridge: ASCII constants, response
// length, FSM state type and the nibble-to-ASCII hex encoder.
package bridge_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_D  = 8'h44;

  // Header + four hex digits + CR + LF
  localparam int MSG_LEN = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Map a nibble to its uppercase ASCII hex digit ('0'-'9', 'A'-'F').
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/bridge_tx.sv
// bridge_tx: turns a 16-bit bus read result into the 7-byte ASCII reply
// RESP_CHAR, 4 hex digits (MSB first), CR, LF, handed to a UART transmitter
// over a valid/ready byte interface. Write completions produce no reply.
// Optional feature macro: BRIDGE_TX_PENDING_EN adds a one-entry buffer for a
// read result that arrives while a reply is still being sent; without it
// such results are discarded and drop_o pulses.
module bridge_tx
  import bridge_pkg::*;
#(
  parameter logic [7:0] RESP_CHAR = 8'h44
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        drop_o
);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [7:0]  byte_q, byte_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;

`ifdef BRIDGE_TX_PENDING_EN
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] pend_data_q, pend_data_d;
`endif

  logic rd_strobe;
  logic accept;
  logic last;

  // Byte of the reply at a given index for a captured data word.
  function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [15:0] d);
    case (idx)
      3'd0:    return RESP_CHAR;
      3'd1:    return nib2ascii(d[15:12]);
      3'd2:    return nib2ascii(d[11:8]);
      3'd3:    return nib2ascii(d[7:4]);
      3'd4:    return nib2ascii(d[3:0]);
      3'd5:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  assign rd_strobe = valid_i && !rw_i;
  // ready_i only counts while a byte is actually on offer
  assign accept    = (state_q == SEND) && valid_q && ready_i;
  assign last      = (idx_q == 3'(MSG_LEN - 1));

  // Next-state logic: sequencing, strobe capture, drop and output byte select
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    drop_d  = 1'b0;
`ifdef BRIDGE_TX_PENDING_EN
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (rd_strobe) begin
          state_d = SEND;
          idx_d   = 3'd0;
          data_d  = data_i;
        end
      end
      default: begin
        if (accept) begin
          if (last) begin
            state_d = IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
`ifdef BRIDGE_TX_PENDING_EN
        if (accept && last && pend_valid_q) begin
          // Chain the buffered reply straight after LF; the slot was still
          // full when this cycle's strobe (if any) arrived, so that one is lost.
          state_d      = SEND;
          idx_d        = 3'd0;
          data_d       = pend_data_q;
          pend_valid_d = 1'b0;
          drop_d       = rd_strobe;
        end else if (accept && last && rd_strobe) begin
          // Strobe on the LF-accept cycle: buffer and consume in one step.
          state_d = SEND;
          idx_d   = 3'd0;
          data_d  = data_i;
        end else if (rd_strobe) begin
          if (pend_valid_q) begin
            drop_d = 1'b1;
          end else begin
            pend_valid_d = 1'b1;
            pend_data_d  = data_i;
          end
        end
`else
        drop_d = rd_strobe;
`endif
      end
    endcase

    valid_d = (state_d == SEND);
    busy_d  = (state_d == SEND);
    byte_d  = (state_d == SEND) ? msg_byte(idx_d, data_d) : 8'h00;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
      byte_q  <= 8'h00;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

`ifdef BRIDGE_TX_PENDING_EN
  // Pending buffer register
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_data_q  <= 16'h0000;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
    end
  end
`endif

  assign data_o  = byte_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign drop_o  = drop_q;

endmodule

// File: tb/tb_bridge_tx.sv
// Testbench for bridge_tx: directed and randomized read/write strobes with
// varying ready_i patterns, checked against a byte-queue reference model.
module tb_bridge_tx;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst;
  logic [15:0] data_i;
  logic        rw_i;
  logic        valid_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        drop_o;

  int cmp_cnt = 0;
  int err_cnt = 0;

  bridge_tx #(.RESP_CHAR(8'h44)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .rw_i    (rw_i),
    .valid_i (valid_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .drop_o  (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference reply: 'D', hex digits high nibble first, CR, LF
  function automatic bq_t msg(input logic [15:0] d);
    bq_t q;
    int  n;
    q.push_back(8'h44);
    for (int i = 3; i >= 0; i--) begin
      n = (d >> (4 * i)) & 15;
      if (n < 10) q.push_back(8'(48 + n));
      else        q.push_back(8'(65 + n - 10));
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic send_read(input logic [15:0] d);
    valid_i = 1'b1;
    rw_i    = 1'b0;
    data_i  = d;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Consume expected bytes; mode 0 = ready high, 1 = toggle 1/0, 2 = random.
  // Optionally injects one strobe when byte index strobe_k is on offer.
  task automatic drain(input bq_t exp, input int mode, input int strobe_k,
                       input logic [15:0] sd, input logic srw, input string tag);
    int acc = 0;
    int iter = 0;
    int ph = 0;
    bit fired = 0;
    bit drop_exp = 0;
    while (exp.size() > 0 && iter < 400) begin
      iter++;
      case (mode)
        0:       ready_i = 1'b1;
        1:       ready_i = (ph == 0);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      ph ^= 1;
      check({tag, "_valid"}, 32'(valid_o), 32'd1);
      check({tag, "_busy"}, 32'(busy_o), 32'd1);
      check({tag, "_data"}, 32'(data_o), 32'(exp[0]));
      check({tag, "_drop"}, 32'(drop_o), 32'(drop_exp));
      if (ready_i) $display("%s: byte %0d = %02h", tag, acc, data_o);
      drop_exp = 1'b0;
      if (!fired && strobe_k >= 0 && acc == strobe_k) begin
        valid_i = 1'b1;
        rw_i    = srw;
        data_i  = sd;
        fired   = 1'b1;
`ifndef BRIDGE_TX_PENDING_EN
        drop_exp = !srw;
`endif
      end
      if (ready_i) begin
        void'(exp.pop_front());
        acc++;
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
    check({tag, "_timeout"}, 32'(exp.size()), 32'd0);
    ready_i = 1'b0;
    check({tag, "_end_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_end_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_end_drop"}, 32'(drop_o), 32'(drop_exp));
  endtask

  initial begin
    bq_t         e;
    logic [15:0] d;
    logic [15:0] sd;
    int          mode;
    int          k;
    logic        srw;

    rst = 1'b1; data_i = '0; rw_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_drop", 32'(drop_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);

    // Read 1234 with ready tied high
    send_read(16'h1234);
    drain(msg(16'h1234), 0, -1, 16'h0, 1'b0, "rd1234");

    // Read ABCF with ready toggling; bytes held while ready low
    send_read(16'hABCF);
    drain(msg(16'hABCF), 1, -1, 16'h0, 1'b0, "rdABCF");

    // Write strobe produces nothing
    valid_i = 1'b1; rw_i = 1'b1; data_i = 16'hFFFF;
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wr_valid", 32'(valid_o), 32'd0);
      check("wr_busy", 32'(busy_o), 32'd0);
      check("wr_drop", 32'(drop_o), 32'd0);
      $display("write: cycle %0d valid=%0b busy=%0b drop=%0b", i, valid_o, busy_o, drop_o);
      @(posedge clk); #1;
    end

    // Read 0001, second read 00A0 while byte 3 is on offer
    e = msg(16'h0001);
`ifdef BRIDGE_TX_PENDING_EN
    e = {e, msg(16'h00A0)};
`endif
    send_read(16'h0001);
    drain(e, 0, 3, 16'h00A0, 1'b0, "overlap");

    // Reset during byte 2 abandons the message
    d = 16'($urandom);
    e = msg(d);
    send_read(d);
    ready_i = 1'b1;
    check("rstmid_b0", 32'(data_o), 32'(e[0]));
    @(posedge clk); #1;
    check("rstmid_b1", 32'(data_o), 32'(e[1]));
    @(posedge clk); #1;
    check("rstmid_b2", 32'(data_o), 32'(e[2]));
    ready_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_valid", 32'(valid_o), 32'd0);
    check("rstmid_busy", 32'(busy_o), 32'd0);
    check("rstmid_data", 32'(data_o), 32'd0);
    @(posedge clk); #1;
    check("rstmid_noresume", 32'(valid_o), 32'd0);
    $display("reset mid-message: valid=%0b busy=%0b", valid_o, busy_o);
    send_read(16'h5678);
    drain(msg(16'h5678), 0, -1, 16'h0, 1'b0, "rd5678");

    // Randomized replies with random ready and an optional overlapping strobe
    for (int t = 0; t < 8; t++) begin
      d    = 16'($urandom);
      sd   = 16'($urandom);
      mode = $urandom_range(0, 2);
      k    = $urandom_range(0, 7);
      if (k == 7) k = -1;
      srw  = 1'($urandom_range(0, 1));
      e    = msg(d);
`ifdef BRIDGE_TX_PENDING_EN
      if (k >= 0 && !srw) e = {e, msg(sd)};
`endif
      send_read(d);
      drain(e, mode, k, sd, srw, $sformatf("rand%0d", t));
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
